// File: rtl/kmap_sweep_pkg.sv
// kmap_sweep_pkg
// Shared types and helpers for the truth-table sweep checker.
//   state_t     : sweep FSM state encoding (IDLE, DRIVE, DONE)
//   num_vectors : number of input vectors swept for an NIN-input block
package kmap_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int num_vectors(input int nin);
    return 1 << nin;
  endfunction

endpackage

// File: rtl/kmap_settle_counter.sv
// kmap_settle_counter
// Modulo-SETTLE cycle counter that paces how long each vector is held.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset, count to 0
//   clr   : synchronous clear, count to 0 (takes priority over en)
//   en    : advance the count; wraps to 0 after the last hold cycle
//   last  : current cycle is the final (sample) cycle of the hold
module kmap_settle_counter #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic last
);

  // Keep at least one bit so SETTLE=1 still elaborates; the count then
  // never leaves 0 and every cycle is a sample cycle.
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (last) cnt <= '0;
      else      cnt <= cnt + CNT_W'(1);
    end
  end

  assign last = (cnt == LAST_CNT);

endmodule

// File: rtl/kmap_sweep_checker.sv
// kmap_sweep_checker
// Sweeps every input vector of a small combinational block, holds each for
// SETTLE cycles, samples f on the last hold cycle and checks it against the
// expected truth table TRUTH (bit i = expected f for vector i).
// Ports:
//   clk           : clock, rising edge
//   reset         : asynchronous active-high reset
//   start         : request a sweep (honoured only when idle)
//   f             : output of the block under test
//   in_vec        : registered vector driven to the block inputs
//   busy          : sweep in progress
//   done          : one-cycle pulse at end of sweep
//   pass          : last sweep had no mismatches (held until next start)
//   err_count     : mismatches in the current/last sweep
//   first_err     : vector index of the first mismatch
//   first_err_vld : first_err holds a valid index
module kmap_sweep_checker
  import kmap_sweep_pkg::*;
#(
  parameter int                     NIN    = 2,
  parameter logic [(1<<NIN)-1:0]    TRUTH  = 4'b0110,
  parameter int                     SETTLE = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           f,
  output logic [NIN-1:0] in_vec,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [NIN:0]   err_count,
  output logic [NIN-1:0] first_err,
  output logic           first_err_vld
);

  localparam int             NVEC     = num_vectors(NIN);
  localparam logic [NIN-1:0] LAST_VEC = NIN'(NVEC - 1);

  state_t         state, state_nxt;
  logic [NIN-1:0] vec;
  logic           hold_last;
  logic           accept;
  logic           sample;
  logic           final_sample;
  logic           mismatch;

  assign accept       = (state == IDLE) && start;
  assign sample       = (state == DRIVE) && hold_last;
  assign final_sample = sample && (vec == LAST_VEC);
  assign mismatch     = sample && (f != TRUTH[vec]);

  // Counter is held at 0 outside DRIVE so every sweep starts a fresh hold.
  kmap_settle_counter #(
    .SETTLE (SETTLE)
  ) u_settle (
    .clk   (clk),
    .reset (reset),
    .clr   (state != DRIVE),
    .en    (state == DRIVE),
    .last  (hold_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = DRIVE;
      DRIVE:   if (final_sample) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // vec doubles as the in_vec register: it holds the last vector through
  // DONE and returns to 0 as the FSM drops back to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vec <= '0;
    end else if (accept) begin
      vec <= '0;
    end else if (sample && !final_sample) begin
      vec <= vec + NIN'(1);
    end else if (state == DONE) begin
      vec <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count     <= '0;
      first_err     <= '0;
      first_err_vld <= 1'b0;
      pass          <= 1'b0;
    end else if (accept) begin
      err_count     <= '0;
      first_err     <= '0;
      first_err_vld <= 1'b0;
      pass          <= 1'b0;
    end else begin
      if (mismatch) begin
        err_count <= err_count + (NIN+1)'(1);
        if (!first_err_vld) begin
          first_err     <= vec;
          first_err_vld <= 1'b1;
        end
      end
      // The last vector's own mismatch lands on this same edge, so fold it
      // in directly rather than waiting for err_count to update.
      if (final_sample) pass <= (err_count == '0) && !mismatch;
    end
  end

  assign in_vec = vec;
  assign busy   = (state == DRIVE);
  assign done   = (state == DONE);

endmodule
